// File: rtl/snn_core_param.sv
// Parametrised two-layer SNN inference core (input -> hidden -> output, argmax digit).
// Optional confidence/margin outputs are enabled by defining SNN_CONF_OUT_EN.
module snn_core_param #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int DW     = 8,
    parameter int LUT_AW = 11,
    parameter int FRAC   = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [$clog2(N_IN)-1:0]          in_addr,
    input  logic                             in_q,
    output logic [$clog2(N_IN*N_HID)-1:0]    hw_addr,
    input  logic [DW-1:0]                    hw_q,
    output logic [$clog2(N_HID*N_OUT)-1:0]   ow_addr,
    input  logic [DW-1:0]                    ow_q,
    output logic [LUT_AW-1:0]                lut_addr,
    input  logic [DW-1:0]                    lut_q,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(N_OUT)-1:0]         digit
`ifdef SNN_CONF_OUT_EN
    ,
    output logic [DW-1:0]                    conf,
    output logic [DW:0]                      margin
`endif
);

    localparam int IAW   = $clog2(N_IN);
    localparam int HAW   = $clog2(N_IN * N_HID);
    localparam int OAW   = $clog2(N_HID * N_OUT);
    localparam int JW    = $clog2(N_HID);
    localparam int DGW   = $clog2(N_OUT);
    localparam int NMAX  = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int ACC_W = 2 * DW + $clog2(NMAX);
    localparam int PW    = 2 * DW;
    localparam int SW    = ACC_W - FRAC;
    localparam int XW    = ((SW > LUT_AW) ? SW : LUT_AW) + 1;

    localparam logic [IAW-1:0] K_LAST = IAW'(N_IN - 1);
    localparam logic [JW-1:0]  J_LAST = JW'(N_HID - 1);
    localparam logic [DGW-1:0] M_LAST = DGW'(N_OUT - 1);

    localparam logic signed [XW-1:0] S_MAX = XW'((2 ** (LUT_AW - 1)) - 1);
    localparam logic signed [XW-1:0] S_MIN = XW'(-(2 ** (LUT_AW - 1)));
    localparam logic [DW-1:0]        A_ONE = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [3:0] {
        IDLE,
        H_MAC,
        H_DRN,
        H_ACT,
        H_WR,
        O_MAC,
        O_DRN,
        O_ACT,
        O_WR,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [IAW-1:0]          k_q;
    logic [JW-1:0]           j_q;
    logic [DGW-1:0]          m_q;
    logic [HAW-1:0]          hw_addr_q;
    logic [OAW-1:0]          ow_addr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    h_v_q, o_v_q;
    logic [DW-1:0]           hid_a_q;
    logic [DW-1:0]           hid_q [N_HID];
    logic [DW-1:0]           max_q, max_d;
    logic [DGW-1:0]          idx_q, idx_d;
    logic [DGW-1:0]          digit_q;

    logic [DW-1:0]           a_op, w_op;
    logic signed [PW-1:0]    a_x, w_x, prod;
    logic signed [XW-1:0]    s_x;
    logic [LUT_AW-1:0]       lut_idx;

`ifdef SNN_CONF_OUT_EN
    localparam logic [DW-1:0] V_MIN = {1'b1, {(DW-1){1'b0}}};
    logic [DW-1:0] sec_q, sec_d;
    logic [DW-1:0] conf_q;
    logic [DW:0]   margin_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        lut_addr = '0;
        unique case (state_q)
            IDLE:    if (start) state_d = H_MAC;
            H_MAC: begin
                busy = 1'b1;
                if (k_q == K_LAST) state_d = H_DRN;
            end
            H_DRN: begin
                busy    = 1'b1;
                state_d = H_ACT;
            end
            H_ACT: begin
                busy     = 1'b1;
                lut_addr = lut_idx;
                state_d  = H_WR;
            end
            H_WR: begin
                busy    = 1'b1;
                state_d = (j_q == J_LAST) ? O_MAC : H_MAC;
            end
            O_MAC: begin
                busy = 1'b1;
                if (j_q == J_LAST) state_d = O_DRN;
            end
            O_DRN: begin
                busy    = 1'b1;
                state_d = O_ACT;
            end
            O_ACT: begin
                busy     = 1'b1;
                lut_addr = lut_idx;
                state_d  = O_WR;
            end
            O_WR: begin
                busy    = 1'b1;
                state_d = (m_q == M_LAST) ? DONE : O_MAC;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // MAC operands arrive one cycle after issue; the valid flags track which layer issued them.
    always_comb begin
        a_op = h_v_q ? (in_q ? A_ONE : '0) : hid_a_q;
        w_op = h_v_q ? hw_q : ow_q;
        a_x  = {{DW{a_op[DW-1]}}, a_op};
        w_x  = {{DW{w_op[DW-1]}}, w_op};
        prod = a_x * w_x;
    end

    always_comb begin
        s_x = {{(XW-SW){acc_q[ACC_W-1]}}, acc_q[ACC_W-1:FRAC]};
        if (s_x > S_MAX) begin
            lut_idx = '1;
        end else if (s_x < S_MIN) begin
            lut_idx = '0;
        end else begin
            lut_idx = {~s_x[LUT_AW-1], s_x[LUT_AW-2:0]};
        end
    end

    // Running argmax; the final update is folded into the last O_WR so digit is valid with done.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
`ifdef SNN_CONF_OUT_EN
        sec_d = sec_q;
`endif
        if (state_q == O_WR) begin
            if (m_q == '0) begin
                max_d = lut_q;
                idx_d = m_q;
`ifdef SNN_CONF_OUT_EN
                sec_d = V_MIN;
`endif
            end else if ($signed(lut_q) > $signed(max_q)) begin
                max_d = lut_q;
                idx_d = m_q;
`ifdef SNN_CONF_OUT_EN
                sec_d = max_q;
            end else if ($signed(lut_q) > $signed(sec_q)) begin
                sec_d = lut_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q       <= '0;
            j_q       <= '0;
            m_q       <= '0;
            hw_addr_q <= '0;
            ow_addr_q <= '0;
            acc_q     <= '0;
            h_v_q     <= 1'b0;
            o_v_q     <= 1'b0;
            hid_a_q   <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            digit_q   <= '0;
`ifdef SNN_CONF_OUT_EN
            sec_q     <= '0;
            conf_q    <= '0;
            margin_q  <= '0;
`endif
        end else begin
            h_v_q <= (state_q == H_MAC);
            o_v_q <= (state_q == O_MAC);
            max_q <= max_d;
            idx_q <= idx_d;
`ifdef SNN_CONF_OUT_EN
            sec_q <= sec_d;
`endif
            if (h_v_q || o_v_q) begin
                acc_q <= acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
            end
            unique case (state_q)
                IDLE: begin
                    k_q       <= '0;
                    j_q       <= '0;
                    m_q       <= '0;
                    hw_addr_q <= '0;
                    ow_addr_q <= '0;
                    acc_q     <= '0;
                end
                H_MAC: begin
                    hw_addr_q <= hw_addr_q + HAW'(1);
                    k_q       <= (k_q == K_LAST) ? '0 : k_q + IAW'(1);
                end
                H_WR: begin
                    acc_q <= '0;
                    if (j_q == J_LAST) begin
                        j_q       <= '0;
                        hw_addr_q <= '0;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                O_MAC: begin
                    hid_a_q   <= hid_q[j_q];
                    ow_addr_q <= ow_addr_q + OAW'(1);
                    j_q       <= (j_q == J_LAST) ? '0 : j_q + JW'(1);
                end
                O_WR: begin
                    acc_q <= '0;
                    if (m_q == M_LAST) begin
                        digit_q   <= idx_d;
`ifdef SNN_CONF_OUT_EN
                        conf_q    <= max_d;
                        margin_q  <= {max_d[DW-1], max_d} - {sec_d[DW-1], sec_d};
`endif
                    end else begin
                        m_q <= m_q + DGW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == H_WR) begin
            hid_q[j_q] <= lut_q;
        end
    end

    assign in_addr = k_q;
    assign hw_addr = hw_addr_q;
    assign ow_addr = ow_addr_q;
    assign digit   = digit_q;
`ifdef SNN_CONF_OUT_EN
    assign conf    = conf_q;
    assign margin  = margin_q;
`endif

endmodule

// File: tb/tb_snn_core_param.sv
// Directed bench for snn_core_param: small 4-2-3 instance with ROM/LUT models, plus a
// default-size instance used only to probe LUT saturation. Checks conf/margin when SNN_CONF_OUT_EN is set.
module tb_snn_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_s, start_b;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Small instance: N_IN=4, N_HID=2, N_OUT=3.
    logic [1:0]  s_in_addr;
    logic        s_in_q;
    logic [2:0]  s_hw_addr;
    logic [7:0]  s_hw_q;
    logic [2:0]  s_ow_addr;
    logic [7:0]  s_ow_q;
    logic [10:0] s_lut_addr;
    logic [7:0]  s_lut_q;
    logic        s_busy, s_done;
    logic [1:0]  s_digit;
`ifdef SNN_CONF_OUT_EN
    logic [7:0]  s_conf, b_conf;
    logic [8:0]  s_margin, b_margin;
`endif

    // Default-size instance.
    logic [9:0]  b_in_addr;
    logic        b_in_q;
    logic [14:0] b_hw_addr;
    logic [7:0]  b_hw_q;
    logic [8:0]  b_ow_addr;
    logic [7:0]  b_ow_q;
    logic [10:0] b_lut_addr;
    logic [7:0]  b_lut_q;
    logic        b_busy, b_done;
    logic [3:0]  b_digit;

    logic       in_mem  [4];
    logic [7:0] hw_mem  [8];
    logic [7:0] ow_mem  [8];
    logic [7:0] lut_mem [2048];
    logic       big_pix;
    logic [7:0] big_w;

    always @(posedge clk) begin
        s_in_q  <= in_mem[s_in_addr];
        s_hw_q  <= hw_mem[s_hw_addr];
        s_ow_q  <= ow_mem[s_ow_addr];
        s_lut_q <= lut_mem[s_lut_addr];
        b_in_q  <= big_pix;
        b_hw_q  <= big_w;
        b_ow_q  <= 8'd0;
        b_lut_q <= 8'd0;
    end

    snn_core_param #(
        .N_IN(4), .N_HID(2), .N_OUT(3), .DW(8), .LUT_AW(11), .FRAC(7)
    ) u_small (
        .clk(clk), .rst(rst), .start(start_s),
        .in_addr(s_in_addr), .in_q(s_in_q),
        .hw_addr(s_hw_addr), .hw_q(s_hw_q),
        .ow_addr(s_ow_addr), .ow_q(s_ow_q),
        .lut_addr(s_lut_addr), .lut_q(s_lut_q),
        .busy(s_busy), .done(s_done), .digit(s_digit)
`ifdef SNN_CONF_OUT_EN
        , .conf(s_conf), .margin(s_margin)
`endif
    );

    snn_core_param u_big (
        .clk(clk), .rst(rst), .start(start_b),
        .in_addr(b_in_addr), .in_q(b_in_q),
        .hw_addr(b_hw_addr), .hw_q(b_hw_q),
        .ow_addr(b_ow_addr), .ow_q(b_ow_q),
        .lut_addr(b_lut_addr), .lut_q(b_lut_q),
        .busy(b_busy), .done(b_done), .digit(b_digit)
`ifdef SNN_CONF_OUT_EN
        , .conf(b_conf), .margin(b_margin)
`endif
    );

    typedef struct {
        logic [0:3]      pix;
        logic [0:7][7:0] hw;
        logic [0:5][7:0] ow;
        bit              lut_alt;
        int              exp_digit;
        int              exp_conf;
        int              exp_margin;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 4; k++) in_mem[k] = v.pix[k];
        for (int k = 0; k < 8; k++) hw_mem[k] = v.hw[k];
        for (int k = 0; k < 6; k++) ow_mem[k] = v.ow[k];
        ow_mem[6] = 8'd0;
        ow_mem[7] = 8'd0;
        for (int a = 0; a < 2048; a++) lut_mem[a] = 8'(a - 1024);
        if (v.lut_alt) begin
            lut_mem[1024] = 8'd40;
            lut_mem[1025] = 8'd55;
            lut_mem[1027] = 8'd52;
        end
    endtask

    // Returns at the cycle done is seen; lat = cycles after the accepting edge, -1 on timeout.
    task automatic run_small(input bit disturb, output int lat, output logic busy1, output logic busyd);
        lat   = -1;
        busy1 = 1'b0;
        busyd = 1'b1;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c == 1) busy1 = s_busy;
            if (s_done) begin
                lat   = c;
                busyd = s_busy;
                break;
            end
            start_s = disturb && (c == 3 || c == 10 || c == 20);
            @(posedge clk); #1;
        end
        start_s = 1'b0;
    endtask

    task automatic probe_big(input logic pix, input logic [7:0] w, output logic [10:0] at785,
                             output logic [10:0] at786, output logic busy786);
        big_pix = pix;
        big_w   = w;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        repeat (784) @(posedge clk);
        #1 at785 = b_lut_addr;
        @(posedge clk); #1;
        at786   = b_lut_addr;
        busy786 = b_busy;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        busy1, busyd, bz;
        logic [10:0] a785, a786;
        int          seen;

        vecs[0] = '{4'b1011, {8{8'd1}},
                    {8'd10, 8'd10, 8'd60, 8'd60, 8'd127, 8'd127}, 1'b0, 2, 3, 2};
        vecs[1] = '{4'b1011, {8{8'd1}},
                    {8'd10, 8'd10, 8'd127, 8'd127, 8'd127, 8'd127}, 1'b0, 1, 3, 0};
        vecs[2] = '{4'b1111, {8'd32, 8'd32, 8'd32, 8'd32, 8'hE0, 8'hE0, 8'hE0, 8'hE0},
                    {8'd0, 8'hEC, 8'd10, 8'd0, 8'hFB, 8'd0}, 1'b0, 0, 19, 10};
        vecs[3] = '{4'b1100, {8'd64, 8'd64, 8'd99, 8'd99, 8'hFF, 8'hFF, 8'd99, 8'd99},
                    {8'hFF, 8'd0, 8'hFE, 8'd0, 8'd0, 8'hCE}, 1'b0, 2, 0, 1};
        vecs[4] = '{4'b1011, {8{8'd1}},
                    {8'd10, 8'd10, 8'd60, 8'd60, 8'd127, 8'd127}, 1'b1, 1, 55, 3};

        rst = 1'b1;
        start_s = 1'b0;
        start_b = 1'b0;
        big_pix = 1'b0;
        big_w   = 8'd0;
        load_vec(vecs[0]);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        seen = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (s_busy || s_done) seen++;
        end
        chk("idle busy/done activity", seen, 0);
        chk("reset busy", s_busy, 0);
        chk("reset done", s_done, 0);
        chk("reset digit", s_digit, 0);
        chk("reset in_addr", s_in_addr, 0);
        chk("reset lut_addr", s_lut_addr, 0);

        for (int i = 0; i < 5; i++) begin
            load_vec(vecs[i]);
            run_small(1'b0, lat, busy1, busyd);
            chk($sformatf("v%0d latency", i), lat, 30);
            chk($sformatf("v%0d busy after accept", i), busy1, 1);
            chk($sformatf("v%0d busy at done", i), busyd, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d done pulse width", i), s_done, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d digit", i), s_digit, vecs[i].exp_digit);
`ifdef SNN_CONF_OUT_EN
            chk($sformatf("v%0d conf", i), $signed(s_conf), vecs[i].exp_conf);
            chk($sformatf("v%0d margin", i), s_margin, vecs[i].exp_margin);
`endif
        end

        // Extra start pulses while busy must not perturb the run.
        load_vec(vecs[0]);
        run_small(1'b1, lat, busy1, busyd);
        chk("disturbed latency", lat, 30);

        // start held during the DONE cycle is ignored.
        start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        chk("done-cycle start: busy next", s_busy, 0);
        @(posedge clk); #1;
        chk("done-cycle start: still idle", s_busy, 0);
        chk("disturbed digit", s_digit, 2);

        // Synchronous reset in the middle of the output layer.
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("busy before mid reset", s_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid reset busy", s_busy, 0);
        chk("mid reset digit", s_digit, 0);
        chk("mid reset ow_addr", s_ow_addr, 0);
        @(posedge clk); #1;
        chk("post reset stays idle", s_busy, 0);
        run_small(1'b0, lat, busy1, busyd);
        chk("post reset latency", lat, 30);
        @(posedge clk); #1;
        chk("post reset digit", s_digit, 2);

        // LUT index saturation on the default-size core.
        probe_big(1'b1, 8'd127, a785, a786, bz);
        chk("big drain lut_addr", a785, 0);
        chk("big positive saturation", a786, 11'h7FF);
        chk("big busy in act", bz, 1);
        probe_big(1'b1, 8'h80, a785, a786, bz);
        chk("big negative saturation", a786, 11'h000);
        probe_big(1'b0, 8'd5, a785, a786, bz);
        chk("big zero index", a786, 11'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
